alu_arbiter: RTL

- Shares one combinational ALU (SrcA/SrcB/Operation -> ALUResult, 4-bit opcode) between two requesters: port 0 = integer pipeline, port 1 = branch/address helper.
- Round-robin grant with valid/ready request handshakes.
- Captures the ALU result in a single output register.
- Returns the result on the granting port's response channel with valid/ready backpressure.

---
 rtl/alu_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters,
// with a single registered result per owner. Define ALU_ARB_STATS_EN for grant/stall counters.
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_a,
  input  logic [DATA_WIDTH-1:0]    req0_b,
  input  logic [OPCODE_LENGTH-1:0] req0_op,

  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_a,
  input  logic [DATA_WIDTH-1:0]    req1_b,
  input  logic [OPCODE_LENGTH-1:0] req1_op,

  output logic                     rsp0_valid,
  input  logic                     rsp0_ready,
  output logic [DATA_WIDTH-1:0]    rsp0_result,

  output logic                     rsp1_valid,
  input  logic                     rsp1_ready,
  output logic [DATA_WIDTH-1:0]    rsp1_result,

  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]    alu_result
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]              grant_cnt0,
  output logic [15:0]              grant_cnt1,
  output logic [15:0]              stall_cnt
`endif
);

  logic                  out_valid;
  logic                  out_owner;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  last_grant;

  logic owner_ready;
  logic free;
  logic grant0;
  logic grant1;
  logic accept;
  logic drain;

  // The output register can be drained and refilled in the same cycle.
  assign owner_ready = out_owner ? rsp1_ready : rsp0_ready;
  assign free        = !out_valid || owner_ready;

  // On a tie the port that did not win last time goes first.
  assign grant0 = !reset && free && req0_valid && (!req1_valid || last_grant);
  assign grant1 = !reset && free && req1_valid && (!req0_valid || !last_grant);
  assign accept = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_srca = '0;
    alu_srcb = '0;
    alu_op   = '0;
    if (grant0) begin
      alu_srca = req0_a;
      alu_srcb = req0_b;
      alu_op   = req0_op;
    end else if (grant1) begin
      alu_srca = req1_a;
      alu_srcb = req1_b;
      alu_op   = req1_op;
    end
  end

  always_comb begin
    rsp0_valid  = !reset && out_valid && !out_owner;
    rsp1_valid  = !reset && out_valid &&  out_owner;
    rsp0_result = rsp0_valid ? out_data : '0;
    rsp1_result = rsp1_valid ? out_data : '0;
  end

  assign drain = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_owner  <= 1'b0;
      out_data   <= '0;
      last_grant <= 1'b1;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_owner  <= grant1;
      out_data   <= alu_result;
      last_grant <= grant1;
    end else if (drain) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic stall;
  assign stall = (req0_valid || req1_valid) && !accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      stall_cnt  <= '0;
    end else begin
      if (grant0 && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (grant1 && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
      if (stall  && stall_cnt  != 16'hFFFF) stall_cnt  <= stall_cnt  + 16'd1;
    end
  end
`endif

endmodule
